// File: rtl/pipelined_add_sub.sv
// Pipelined adder/subtractor: one CHUNK-bit slice resolved per stage, carry rippled
// between stages, valid/ready handshake with whole-pipeline freeze on backpressure.
module pipelined_add_sub #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sub_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] r_o,
   output logic             carry_o,
   output logic             zero_o,
   output logic             overflow_o,
   output logic             negative_o
);

   localparam int unsigned STAGES = WIDTH / CHUNK;
   localparam int unsigned LAST   = STAGES - 1;
   localparam int unsigned SUM_W  = CHUNK + 1;

   if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_width
      $error("pipelined_add_sub: WIDTH must be a non-zero multiple of CHUNK");
   end

   // Per-stage payload; a/b hold only the operand slices not yet consumed,
   // always right-aligned so each stage works on bits [CHUNK-1:0].
   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] res;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             carry;
      logic             zero;
      logic             a_msb;
      logic             b_msb;
      logic             ovf;
   } stage_t;

   stage_t           stage_q [STAGES];
   stage_t           stage_d [STAGES];
   stage_t           src     [STAGES];
   logic             advance;
   logic [SUM_W-1:0] slice_sum;

   // Next-state: each stage adds its slice; nothing moves while the output is stalled.
   always_comb begin
      advance = !stage_q[LAST].valid || ready_i;

      src[0]       = '0;
      src[0].valid = valid_i;
      src[0].a     = a_i;
      src[0].b     = b_i ^ {WIDTH{sub_i}};
      src[0].carry = sub_i;
      src[0].zero  = 1'b1;
      src[0].a_msb = a_i[WIDTH-1];
      src[0].b_msb = b_i[WIDTH-1] ^ sub_i;
      for (int unsigned k = 1; k < STAGES; k++) begin
         src[k] = stage_q[k-1];
      end

      slice_sum = '0;
      stage_d   = stage_q;
      for (int unsigned k = 0; k < STAGES; k++) begin
         slice_sum = {1'b0, src[k].a[CHUNK-1:0]} + {1'b0, src[k].b[CHUNK-1:0]}
                   + SUM_W'(src[k].carry);
         if (advance) begin
            stage_d[k]       = src[k];
            stage_d[k].a     = src[k].a >> CHUNK;
            stage_d[k].b     = src[k].b >> CHUNK;
            // Slices enter at the top and shift down, so slice 0 lands at bit 0 last.
            stage_d[k].res   = (src[k].res >> CHUNK)
                             | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
            stage_d[k].carry = slice_sum[CHUNK];
            stage_d[k].zero  = src[k].zero && (slice_sum[CHUNK-1:0] == '0);
            stage_d[k].ovf   = (k == LAST) && (src[k].a_msb == src[k].b_msb)
                             && (slice_sum[CHUNK-1] != src[k].a_msb);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign ready_o    = advance;
   assign valid_o    = stage_q[LAST].valid;
   assign r_o        = stage_q[LAST].res;
   assign carry_o    = stage_q[LAST].carry;
   assign zero_o     = stage_q[LAST].zero;
   assign overflow_o = stage_q[LAST].ovf;
   assign negative_o = stage_q[LAST].res[WIDTH-1];

endmodule
